// File: rtl/button_debounce_fsm.sv
// Multi-channel button debouncer: two-flop synchronizer per bit, then a per-channel
// stable-time FSM that emits a registered clean level and a one-cycle change pulse.
module button_debounce_fsm #(
  parameter int PARM_BTN_COUNT = 4,
  parameter int PARM_TIME_MAX  = 1000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PARM_BTN_COUNT-1:0] i_btns,
  output logic [PARM_BTN_COUNT-1:0] o_btns_deb,
  output logic [PARM_BTN_COUNT-1:0] o_btns_changed
);

  localparam int CNT_W = $clog2(PARM_TIME_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PARM_TIME_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [1:0] {
    ST_ZERO      = 2'd0,
    ST_WAIT_ONE  = 2'd1,
    ST_ONE       = 2'd2,
    ST_WAIT_ZERO = 2'd3
  } state_t;

  logic [PARM_BTN_COUNT-1:0] sync1_r;
  logic [PARM_BTN_COUNT-1:0] sync2_r;
  state_t                    state_r [PARM_BTN_COUNT];
  logic [CNT_W-1:0]          cnt_r   [PARM_BTN_COUNT];
  logic [PARM_BTN_COUNT-1:0] deb_next_s;

  // Two-stage synchronizer for the raw asynchronous inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= {PARM_BTN_COUNT{1'b0}};
      sync2_r <= {PARM_BTN_COUNT{1'b0}};
    end else begin
      sync1_r <= i_btns;
      sync2_r <= sync1_r;
    end
  end

  // Per-channel qualification FSM and stable-time counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PARM_BTN_COUNT; i++) begin
        state_r[i] <= ST_ZERO;
        cnt_r[i]   <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < PARM_BTN_COUNT; i++) begin
        case (state_r[i])
          ST_ZERO: begin
            if (sync2_r[i]) begin
              state_r[i] <= ST_WAIT_ONE;
              cnt_r[i]   <= CNT_ZERO;
            end else begin
              state_r[i] <= ST_ZERO;
            end
          end
          ST_WAIT_ONE: begin
            if (!sync2_r[i]) begin
              state_r[i] <= ST_ZERO;
            end else if (cnt_r[i] == CNT_LAST) begin
              state_r[i] <= ST_ONE;
            end else begin
              cnt_r[i] <= cnt_r[i] + CNT_ONE;
            end
          end
          ST_ONE: begin
            if (!sync2_r[i]) begin
              state_r[i] <= ST_WAIT_ZERO;
              cnt_r[i]   <= CNT_ZERO;
            end else begin
              state_r[i] <= ST_ONE;
            end
          end
          ST_WAIT_ZERO: begin
            if (sync2_r[i]) begin
              state_r[i] <= ST_ONE;
            end else if (cnt_r[i] == CNT_LAST) begin
              state_r[i] <= ST_ZERO;
            end else begin
              cnt_r[i] <= cnt_r[i] + CNT_ONE;
            end
          end
          default: begin
            state_r[i] <= ST_ZERO;
            cnt_r[i]   <= CNT_ZERO;
          end
        endcase
      end
    end
  end

  // Clean level implied by each channel's present state
  always_comb begin
    deb_next_s = {PARM_BTN_COUNT{1'b0}};
    for (int i = 0; i < PARM_BTN_COUNT; i++) begin
      if ((state_r[i] == ST_ONE) || (state_r[i] == ST_WAIT_ZERO)) begin
        deb_next_s[i] = 1'b1;
      end else begin
        deb_next_s[i] = 1'b0;
      end
    end
  end

  // Registered level and change pulse, so downstream one-shots see no glitches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_btns_deb     <= {PARM_BTN_COUNT{1'b0}};
      o_btns_changed <= {PARM_BTN_COUNT{1'b0}};
    end else begin
      o_btns_deb     <= deb_next_s;
      o_btns_changed <= deb_next_s ^ o_btns_deb;
    end
  end

endmodule
